// File: rtl/pulse_stretch_pkg.sv
// -----------------------------------------------------------------------------
// pulse_stretch_pkg
// Shared definitions for the pulse stretcher:
//   state_t   - FSM state encoding (IDLE, ACTIVE, GAP); 2'b11 is unused/illegal
//   PEND_W    - width of the pending-event counter used by the queued build
//   PEND_MAX  - saturation value of the pending-event counter
//   is_busy   - decode of "not idle" for the legal busy states
// -----------------------------------------------------------------------------
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    GAP    = 2'b10
  } state_t;

  localparam int PEND_W = 3;
  localparam logic [PEND_W-1:0] PEND_MAX = 3'd7;

  // Only the two legal non-idle states count as busy; an undecodable
  // encoding is recovered to IDLE on the next edge and is not treated as busy.
  function automatic logic is_busy(input state_t s);
    return (s == ACTIVE) || (s == GAP);
  endfunction

  // True for any of the three defined encodings.
  function automatic logic is_legal(input state_t s);
    return (s == IDLE) || (s == ACTIVE) || (s == GAP);
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// -----------------------------------------------------------------------------
// pulse_stretch
// Turns a single-cycle trigger into a level that is high for exactly
// HIGH_CYCLES clocks, followed by a low gap of at least LOW_CYCLES clocks
// before another pulse may start. One N-bit down counter times both phases.
//
// Parameters:
//   N            - width of the shared duration counter
//   HIGH_CYCLES  - pulse high time in clk cycles (1 .. 2^N-1)
//   LOW_CYCLES   - minimum low gap after each pulse (1 .. 2^N-1)
//
// Ports:
//   clk        in   system clock, rising-edge active
//   reset_n    in   asynchronous active-low reset
//   trig       in   single-cycle event request
//   pulse      out  stretched level, high only in ACTIVE
//   busy       out  high in ACTIVE and GAP
//   done_tick  out  strobe during the last high cycle of each pulse
//   drop_tick  out  strobe when a trig is discarded
//
// Build option:
//   PULSE_STRETCH_QUEUE_EN - when defined, triggers arriving while busy are
//   counted in a 3-bit saturating pending counter and replayed back-to-back
//   (separated by exactly LOW_CYCLES). When undefined, such triggers are
//   discarded and flagged on drop_tick.
// -----------------------------------------------------------------------------
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int N           = 21,
  parameter int HIGH_CYCLES = 1_500_000,
  parameter int LOW_CYCLES  = 500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trig,
  output logic pulse,
  output logic busy,
  output logic done_tick,
  output logic drop_tick
);

  // Counter reload values: a phase of K cycles counts K-1 down to 0.
  localparam logic [N-1:0] HIGH_LOAD = N'(HIGH_CYCLES - 1);
  localparam logic [N-1:0] LOW_LOAD  = N'(LOW_CYCLES - 1);
  localparam logic [N-1:0] CNT_ONE   = N'(1);

  state_t         state_r;
  state_t         state_s;
  logic [N-1:0]   count_r;
  logic [N-1:0]   count_s;
  logic           pulse_r;
  logic           busy_r;
  logic           count_zero_s;
  logic           busy_s;
  logic           launch_s;

  assign count_zero_s = (count_r == '0);
  assign busy_s       = is_busy(state_r);

`ifdef PULSE_STRETCH_QUEUE_EN

  logic [PEND_W-1:0] pend_r;
  logic [PEND_W-1:0] pend_s;
  logic              gap_end_s;

  assign gap_end_s = (state_r == GAP) && count_zero_s;

  // Pending-event bookkeeping, relaunch decision and drop detection.
  // A trig arriving in the final gap cycle is consumed by the relaunch
  // itself, so the count is left unchanged in that case (and a trig with an
  // empty queue still starts the next pulse without a glitch).
  always_comb begin
    pend_s    = pend_r;
    launch_s  = 1'b0;
    drop_tick = 1'b0;
    if (!is_legal(state_r)) begin
      pend_s = '0;
    end else if (gap_end_s) begin
      launch_s = (pend_r != '0) || trig;
      if (launch_s && !trig) begin
        pend_s = pend_r - 3'd1;
      end else begin
        pend_s = pend_r;
      end
    end else if (busy_s && trig) begin
      if (pend_r == PEND_MAX) begin
        drop_tick = 1'b1;
      end else begin
        pend_s = pend_r + 3'd1;
      end
    end else begin
      pend_s = pend_r;
    end
  end

  // Pending-event counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_r <= '0;
    end else begin
      pend_r <= pend_s;
    end
  end

`else

  // Without the queue a finished gap always returns to IDLE.
  assign launch_s = 1'b0;

  // Any trig seen while busy is discarded and reported.
  always_comb begin
    drop_tick = 1'b0;
    if (busy_s && trig) begin
      drop_tick = 1'b1;
    end else begin
      drop_tick = 1'b0;
    end
  end

`endif

  // Next-state and counter logic; done_tick marks the last high cycle.
  always_comb begin
    state_s   = state_r;
    count_s   = count_r;
    done_tick = 1'b0;
    case (state_r)
      IDLE: begin
        if (trig) begin
          state_s = ACTIVE;
          count_s = HIGH_LOAD;
        end else begin
          state_s = IDLE;
          count_s = '0;
        end
      end
      ACTIVE: begin
        if (count_zero_s) begin
          done_tick = 1'b1;
          state_s   = GAP;
          count_s   = LOW_LOAD;
        end else begin
          state_s   = ACTIVE;
          count_s   = count_r - CNT_ONE;
        end
      end
      GAP: begin
        if (count_zero_s) begin
          if (launch_s) begin
            state_s = ACTIVE;
            count_s = HIGH_LOAD;
          end else begin
            state_s = IDLE;
            count_s = '0;
          end
        end else begin
          state_s = GAP;
          count_s = count_r - CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        count_s = '0;
      end
    endcase
  end

  // State and duration counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      count_r <= '0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
    end
  end

  // Level outputs are registered from the next state so they are glitch-free
  // and track the state register exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      pulse_r <= (state_s == ACTIVE);
      busy_r  <= is_busy(state_s);
    end
  end

  assign pulse = pulse_r;
  assign busy  = busy_r;

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 Parameter: N, 21, width of the shared duration counter.
REQ-002 Parameter: HIGH_CYCLES, 1_500_000, output high time in clk cycles; legal range 1..2^N-1.
REQ-003 Parameter: LOW_CYCLES, 500_000, minimum output low gap after each pulse; legal range 1..2^N-1.
REQ-004 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: trig  input  1  single-cycle event request, synchronous to clk.
REQ-007 Port: pulse  output  1  stretched level, high for exactly HIGH_CYCLES cycles per accepted event.
REQ-008 Port: busy  output  1  high whenever the state is not IDLE.
REQ-009 Port: done_tick  output  1  one-cycle strobe in the last high cycle of each pulse.
REQ-010 Port: drop_tick  output  1  one-cycle strobe when a trig is discarded.

Function
REQ-011 FSM states: IDLE, ACTIVE, GAP; pulse = 1 only in ACTIVE (Moore); busy = 1 in ACTIVE and GAP.
REQ-012 IDLE, trig=1 at edge k -> ACTIVE after edge k, counter loaded with HIGH_CYCLES-1; pulse high from edge k onward.
REQ-013 ACTIVE: counter decrements each cycle; at count==0 -> GAP, counter loaded with LOW_CYCLES-1; done_tick=1 combinationally in that count==0 cycle.
REQ-014 GAP: counter decrements each cycle; at count==0 -> ACTIVE (reload HIGH_CYCLES-1) if an event is pending, else IDLE.
REQ-015 Pulses are therefore exactly HIGH_CYCLES high, separated by exactly LOW_CYCLES low, with no 1-cycle glitch between back-to-back pulses.
REQ-016 trig while busy is handled per the Configuration section; trig never extends or restarts a pulse in progress.
REQ-017 Counter is N bits, unsigned, never wraps: every reload precedes any decrement below zero.
REQ-018 Illegal states (encoding decode miss) -> IDLE on next edge, counter cleared.

Reset
REQ-019 reset_n=0 forces IDLE, counter=0, pending=0 immediately, regardless of clk.
REQ-020 During and after reset until first accepted trig: pulse=0, busy=0, done_tick=0, drop_tick=0.
REQ-021 Reset asserted mid-pulse truncates it at once; no done_tick is issued for the truncated pulse.
REQ-022 First edge after reset_n deasserts may accept trig normally.

Configuration
REQ-023 Macro PULSE_STRETCH_QUEUE_EN absent: trig while busy is discarded and drop_tick=1 in that cycle.
REQ-024 Macro PULSE_STRETCH_QUEUE_EN defined: 3-bit saturating pending counter; trig while busy increments it; GAP exit with pending>0 decrements it and enters ACTIVE.
REQ-025 With queue: trig coinciding with the decrement leaves pending unchanged; trig with pending==7 and no decrement is discarded with drop_tick=1.

Structure
REQ-026 Shared package holds state typedef/localparams (IDLE, ACTIVE, GAP), PEND_W=3, PEND_MAX=7.
REQ-027 No sub-module; single FSM + counter, registered state, combinational next-state block.

Verification (HIGH_CYCLES=4, LOW_CYCLES=2)
REQ-028 Single trig at cycle 10 -> pulse high cycles 11-14, done_tick only at cycle 14, busy high 11-16, IDLE at 17.
REQ-029 No macro, trig at 10 and 12 -> one pulse only, drop_tick at 12.
REQ-030 Macro, trig at 10, 11, 12 -> three pulses (11-14, 17-20, 23-26), lows exactly 2 cycles, no drop_tick.
REQ-031 Macro, 9 trigs while busy -> pending saturates at 7, drop_tick on 8th and 9th, total 8 pulses.
REQ-032 reset_n low at cycle 12 of a pulse -> pulse=0 and busy=0 same cycle, no done_tick; trig at cycle 20 after release -> clean 4-cycle pulse.
